h264_xfrm_arbiter: RTL and testbench

- Shares the single forward transform/quant core between two residual producers: the intra4x4 luma path (requester L) and the chroma path (requester C).
- Grants the core for fixed-length bursts of 4-sample residual rows and forwards the granted requester's strobe and data with one register stage.
- Inserts a turnaround gap between bursts.
- Sits between the intra predictors and the core; the core's READY gates new grants.

---
 rtl/h264_xfrm_arbiter.sv | 172 +++++++++++++++++
 tb/tb_h264_xfrm_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/h264_xfrm_arbiter.sv
// Round-robin arbiter that shares the forward transform/quant core between
// the intra4x4 luma path (L) and the chroma path (C). A grant covers a fixed
// burst of strobed residual rows; strobe and data reach the core one register
// stage later. Each burst is followed by a turnaround gap.
//
// Handshake: x_REQ is a level that the requester holds until x_GNT rises, and
// it is only looked at in IDLE. x_STROBE marks a valid row and is accepted only
// while x_GNT=1. A strobe from a non-granted requester is dropped and sets the
// sticky PROTO_ERR flag. CORE_READY is only consulted when a grant is being
// decided.
module h264_xfrm_arbiter #(
   parameter int WIDTH = 9,
   parameter int BURST = 4,
   parameter int GAP   = 2
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 L_REQ,
   input  logic                 L_STROBE,
   input  logic [4*WIDTH-1:0]   L_DATA,
   input  logic                 C_REQ,
   input  logic                 C_STROBE,
   input  logic [4*WIDTH-1:0]   C_DATA,
   input  logic                 CORE_READY,
   output logic                 L_GNT,
   output logic                 C_GNT,
   output logic                 CORE_STROBE,
   output logic [4*WIDTH-1:0]   CORE_DATA,
   output logic                 CORE_SRC,
   output logic                 CORE_LAST,
   output logic                 BUSY,
   output logic                 PROTO_ERR
);

   localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT_L = 2'd1,
      S_GRANT_C = 2'd2,
      S_GAP     = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [GW-1:0]        gap_q, gap_d;
   logic                 last_c_q, last_c_d;
   logic                 core_strobe_q, core_strobe_d;
   logic [4*WIDTH-1:0]   core_data_q, core_data_d;
   logic                 core_src_q, core_src_d;
   logic                 core_last_q, core_last_d;
   logic                 proto_err_q, proto_err_d;

   logic                 l_gnt, c_gnt;
   state_t               after_burst;

   // Grants are decoded straight from the state register, so they are glitch-free
   // and rise one cycle after the IDLE decision.
   assign l_gnt       = (state_q == S_GRANT_L);
   assign c_gnt       = (state_q == S_GRANT_C);
   assign after_burst = (GAP > 0) ? S_GAP : S_IDLE;

   // Next-state, burst counting, forwarding and error detection.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      gap_d         = gap_q;
      last_c_d      = last_c_q;
      core_strobe_d = 1'b0;
      core_data_d   = core_data_q;
      core_src_d    = core_src_q;
      core_last_d   = 1'b0;
      proto_err_d   = proto_err_q;

      // A strobe from whoever does not own the core is dropped and flagged.
      if ((L_STROBE && !l_gnt) || (C_STROBE && !c_gnt)) begin
         proto_err_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (CORE_READY) begin
               // On a tie, last_c_q=1 means C went last, so L wins.
               if (L_REQ && (!C_REQ || last_c_q)) begin
                  state_d  = S_GRANT_L;
                  last_c_d = 1'b0;
               end else if (C_REQ) begin
                  state_d  = S_GRANT_C;
                  last_c_d = 1'b1;
               end
            end
         end
         S_GRANT_L: begin
            if (L_STROBE) begin
               core_strobe_d = 1'b1;
               core_data_d   = L_DATA;
               core_src_d    = 1'b0;
               if (cnt_q == CNT_LAST) begin
                  core_last_d = 1'b1;
                  cnt_d       = '0;
                  state_d     = after_burst;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         S_GRANT_C: begin
            if (C_STROBE) begin
               core_strobe_d = 1'b1;
               core_data_d   = C_DATA;
               core_src_d    = 1'b1;
               if (cnt_q == CNT_LAST) begin
                  core_last_d = 1'b1;
                  cnt_d       = '0;
                  state_d     = after_burst;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) begin
               gap_d   = '0;
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         gap_q         <= '0;
         last_c_q      <= 1'b1;
         core_strobe_q <= 1'b0;
         core_data_q   <= '0;
         core_src_q    <= 1'b0;
         core_last_q   <= 1'b0;
         proto_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         gap_q         <= gap_d;
         last_c_q      <= last_c_d;
         core_strobe_q <= core_strobe_d;
         core_data_q   <= core_data_d;
         core_src_q    <= core_src_d;
         core_last_q   <= core_last_d;
         proto_err_q   <= proto_err_d;
      end
   end

   assign L_GNT       = l_gnt;
   assign C_GNT       = c_gnt;
   assign CORE_STROBE = core_strobe_q;
   assign CORE_DATA   = core_data_q;
   assign CORE_SRC    = core_src_q;
   assign CORE_LAST   = core_last_q;
   assign BUSY        = (state_q != S_IDLE);
   assign PROTO_ERR   = proto_err_q;

endmodule

// File: tb/tb_h264_xfrm_arbiter.sv
// Directed bench for h264_xfrm_arbiter (WIDTH=9, BURST=4, GAP=2).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_h264_xfrm_arbiter;

   localparam int DW = 36;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          L_REQ = 1'b0, L_STROBE = 1'b0;
   logic [DW-1:0] L_DATA = '0;
   logic          C_REQ = 1'b0, C_STROBE = 1'b0;
   logic [DW-1:0] C_DATA = '0;
   logic          CORE_READY = 1'b0;
   logic          L_GNT, C_GNT, CORE_STROBE, CORE_SRC, CORE_LAST, BUSY, PROTO_ERR;
   logic [DW-1:0] CORE_DATA;

   int n_cmp = 0;
   int n_err = 0;

   h264_xfrm_arbiter #(.WIDTH(9), .BURST(4), .GAP(2)) dut (
      .CLK(CLK), .RST(RST),
      .L_REQ(L_REQ), .L_STROBE(L_STROBE), .L_DATA(L_DATA),
      .C_REQ(C_REQ), .C_STROBE(C_STROBE), .C_DATA(C_DATA),
      .CORE_READY(CORE_READY),
      .L_GNT(L_GNT), .C_GNT(C_GNT),
      .CORE_STROBE(CORE_STROBE), .CORE_DATA(CORE_DATA),
      .CORE_SRC(CORE_SRC), .CORE_LAST(CORE_LAST),
      .BUSY(BUSY), .PROTO_ERR(PROTO_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      L_REQ = 0; L_STROBE = 0; L_DATA = '0;
      C_REQ = 0; C_STROBE = 0; C_DATA = '0;
      CORE_READY = 0;
      RST = 1;
      step();
      step();
      RST = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({L_GNT, C_GNT, CORE_STROBE, CORE_SRC, CORE_LAST, BUSY, PROTO_ERR} !== 7'b0) begin
         n_err++;
         $display("FAIL reset_flags: got %b want 0000000",
                  {L_GNT, C_GNT, CORE_STROBE, CORE_SRC, CORE_LAST, BUSY, PROTO_ERR});
      end
      n_cmp++;
      if (CORE_DATA !== '0) begin
         n_err++;
         $display("FAIL reset_data: got %h want 0", CORE_DATA);
      end
   endtask

   task automatic test_single_luma();
      logic [DW-1:0] exp_d;
      do_reset();
      CORE_READY = 1; L_REQ = 1;
      step();
      n_cmp++;
      if ({L_GNT, C_GNT, BUSY} !== 3'b101) begin
         n_err++;
         $display("FAIL single_gnt: got L/C/BUSY %b want 101", {L_GNT, C_GNT, BUSY});
      end
      L_REQ = 0;
      for (int i = 0; i < 4; i++) begin
         exp_d = {9'h1F0, 9'h003, 9'h002, 9'(i + 1)};
         L_STROBE = 1; L_DATA = exp_d;
         step();
         n_cmp++;
         if ({CORE_STROBE, CORE_SRC, CORE_LAST, L_GNT} !== {1'b1, 1'b0, (i == 3), (i != 3)}) begin
            n_err++;
            $display("FAIL single_word%0d_ctl: got stb/src/last/gnt %b want %b", i,
                     {CORE_STROBE, CORE_SRC, CORE_LAST, L_GNT}, {1'b1, 1'b0, (i == 3), (i != 3)});
         end
         n_cmp++;
         if (CORE_DATA !== exp_d) begin
            n_err++;
            $display("FAIL single_word%0d_data: got %h want %h", i, CORE_DATA, exp_d);
         end
      end
      L_STROBE = 0;
      step();
      n_cmp++;
      if ({BUSY, CORE_STROBE, CORE_LAST, L_GNT} !== 4'b1000) begin
         n_err++;
         $display("FAIL single_gap: got busy/stb/last/gnt %b want 1000",
                  {BUSY, CORE_STROBE, CORE_LAST, L_GNT});
      end
      step();
      n_cmp++;
      if (BUSY !== 1'b0) begin
         n_err++;
         $display("FAIL single_idle: got BUSY %b want 0", BUSY);
      end
   endtask

   task automatic test_round_robin();
      int  lasts = 0;
      int  overlaps = 0;
      logic exp_c;
      logic [DW-1:0] exp_d;
      do_reset();
      CORE_READY = 1; L_REQ = 1; C_REQ = 1;
      for (int b = 0; b < 4; b++) begin
         exp_c = (b % 2) == 1;
         step();
         n_cmp++;
         if ({L_GNT, C_GNT} !== (exp_c ? 2'b01 : 2'b10)) begin
            n_err++;
            $display("FAIL rr_order%0d: got L/C %b want %b", b, {L_GNT, C_GNT},
                     (exp_c ? 2'b01 : 2'b10));
         end
         for (int w = 0; w < 4; w++) begin
            exp_d = DW'(b * 16 + w + 32'h50);
            L_STROBE = !exp_c; C_STROBE = exp_c;
            L_DATA = exp_d; C_DATA = exp_d;
            step();
            if (L_GNT && C_GNT) overlaps++;
            if (CORE_LAST) lasts++;
            n_cmp++;
            if ({CORE_STROBE, CORE_SRC} !== {1'b1, exp_c} || CORE_DATA !== exp_d) begin
               n_err++;
               $display("FAIL rr_word%0d_%0d: got stb/src %b data %h want %b data %h", b, w,
                        {CORE_STROBE, CORE_SRC}, CORE_DATA, {1'b1, exp_c}, exp_d);
            end
         end
         L_STROBE = 0; C_STROBE = 0;
         if (b == 3) begin
            L_REQ = 0; C_REQ = 0;
         end
         for (int g = 0; g < 2; g++) begin
            step();
            if (L_GNT && C_GNT) overlaps++;
            if (CORE_LAST) lasts++;
            n_cmp++;
            if ({L_GNT, C_GNT} !== 2'b00) begin
               n_err++;
               $display("FAIL rr_gap%0d_%0d: got L/C %b want 00", b, g, {L_GNT, C_GNT});
            end
         end
      end
      n_cmp++;
      if (lasts !== 4) begin
         n_err++;
         $display("FAIL rr_last_count: got %0d want 4", lasts);
      end
      n_cmp++;
      if (overlaps !== 0) begin
         n_err++;
         $display("FAIL rr_overlap: got %0d want 0", overlaps);
      end
   endtask

   task automatic test_core_ready();
      int bad = 0;
      do_reset();
      CORE_READY = 0; L_REQ = 1;
      repeat (10) begin
         step();
         if (L_GNT || BUSY) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin
         n_err++;
         $display("FAIL ready_hold: got %0d granted cycles want 0", bad);
      end
      CORE_READY = 1;
      step();
      n_cmp++;
      if (L_GNT !== 1'b1) begin
         n_err++;
         $display("FAIL ready_gnt: got L_GNT %b want 1", L_GNT);
      end
      L_REQ = 0;
   endtask

   task automatic test_gapped_strobes();
      logic [DW-1:0] exp_d = '0;
      int   words = 0;
      logic s;
      do_reset();
      CORE_READY = 1; C_REQ = 1;
      step();
      n_cmp++;
      if ({L_GNT, C_GNT} !== 2'b01) begin
         n_err++;
         $display("FAIL gapped_gnt: got L/C %b want 01", {L_GNT, C_GNT});
      end
      C_REQ = 0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         s = (cyc == 0) || (cyc == 2) || (cyc == 3) || (cyc == 7);
         C_STROBE = s;
         C_DATA = DW'(32'hA00 + cyc);
         step();
         if (s) begin
            words++;
            exp_d = DW'(32'hA00 + cyc);
         end
         n_cmp++;
         if ({CORE_STROBE, CORE_LAST, C_GNT} !== {s, (s && words == 4), (words < 4)} ||
             CORE_DATA !== exp_d || (s && CORE_SRC !== 1'b1)) begin
            n_err++;
            $display("FAIL gapped_cyc%0d: got stb/last/gnt/src %b data %h want %b/1 data %h", cyc,
                     {CORE_STROBE, CORE_LAST, C_GNT, CORE_SRC}, CORE_DATA,
                     {s, (s && words == 4), (words < 4)}, exp_d);
         end
      end
      C_STROBE = 0;
   endtask

   task automatic test_proto_err();
      do_reset();
      CORE_READY = 1; L_REQ = 1;
      step();
      L_REQ = 0;
      n_cmp++;
      if (PROTO_ERR !== 1'b0) begin
         n_err++;
         $display("FAIL proto_clean: got %b want 0", PROTO_ERR);
      end
      for (int w = 0; w < 4; w++) begin
         L_STROBE = 1; L_DATA = DW'(32'h100 + w);
         C_STROBE = (w == 1); C_DATA = DW'(32'hFFF);
         step();
         n_cmp++;
         if ({CORE_STROBE, CORE_SRC, CORE_LAST, PROTO_ERR} !== {1'b1, 1'b0, (w == 3), (w >= 1)} ||
             CORE_DATA !== DW'(32'h100 + w)) begin
            n_err++;
            $display("FAIL proto_word%0d: got stb/src/last/err %b data %h want %b data %h", w,
                     {CORE_STROBE, CORE_SRC, CORE_LAST, PROTO_ERR}, CORE_DATA,
                     {1'b1, 1'b0, (w == 3), (w >= 1)}, DW'(32'h100 + w));
         end
      end
      L_STROBE = 0; C_STROBE = 0;
      step();
      step();
      // Stray C strobe in IDLE: still dropped, flag stays set.
      C_STROBE = 1; C_DATA = DW'(32'h777);
      step();
      C_STROBE = 0;
      n_cmp++;
      if ({CORE_STROBE, PROTO_ERR, BUSY} !== 3'b010 || CORE_DATA !== DW'(32'h103)) begin
         n_err++;
         $display("FAIL proto_sticky: got stb/err/busy %b data %h want 010 data 103",
                  {CORE_STROBE, PROTO_ERR, BUSY}, CORE_DATA);
      end
      do_reset();
      n_cmp++;
      if (PROTO_ERR !== 1'b0) begin
         n_err++;
         $display("FAIL proto_reset_clear: got %b want 0", PROTO_ERR);
      end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      CORE_READY = 1; L_REQ = 1;
      step();
      L_REQ = 0;
      for (int w = 0; w < 2; w++) begin
         L_STROBE = 1; L_DATA = DW'(32'h200 + w);
         step();
      end
      L_DATA = DW'(32'h333);
      RST = 1;
      step();
      n_cmp++;
      if ({L_GNT, C_GNT, CORE_STROBE, CORE_SRC, CORE_LAST, BUSY, PROTO_ERR} !== 7'b0 ||
          CORE_DATA !== '0) begin
         n_err++;
         $display("FAIL midrst_outputs: got flags %b data %h want 0000000 data 0",
                  {L_GNT, C_GNT, CORE_STROBE, CORE_SRC, CORE_LAST, BUSY, PROTO_ERR}, CORE_DATA);
      end
      RST = 0; L_STROBE = 0;
      L_REQ = 1; C_REQ = 1;
      step();
      n_cmp++;
      if ({L_GNT, C_GNT} !== 2'b10) begin
         n_err++;
         $display("FAIL midrst_tie: got L/C %b want 10", {L_GNT, C_GNT});
      end
      L_REQ = 0;
      for (int w = 0; w < 4; w++) begin
         L_STROBE = 1; L_DATA = DW'(32'h400 + w);
         step();
         n_cmp++;
         if (CORE_LAST !== (w == 3)) begin
            n_err++;
            $display("FAIL midrst_last%0d: got %b want %b", w, CORE_LAST, (w == 3));
         end
      end
      L_STROBE = 0; C_REQ = 0;
   endtask

   initial begin
      test_reset();
      test_single_luma();
      test_round_robin();
      test_core_ready();
      test_gapped_strobes();
      test_proto_err();
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
